// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its program store.
package instr_sequencer_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int WORD_W     = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam logic [3:0]        OP_HALT  = 4'b1111;
  localparam logic [WORD_W-1:0] NOP_WORD = 20'h00000;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_1110 = 4'b1110;
  localparam logic [3:0] OP_1100 = 4'b1100;
  localparam logic [3:0] OP_1000 = 4'b1000;
  localparam logic [3:0] OP_1010 = 4'b1010;

  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return word[19:16] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// 16 x 20-bit program store: synchronous write, asynchronous read, cleared by reset.
module seq_prog_ram
  import instr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [PROG_DEPTH];
  logic [WORD_W-1:0] mem_d [PROG_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= NOP_WORD;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: IDLE/RUN/DONE FSM issuing one stored word per cycle.
// Optional single-step mode is enabled by defining SEQ_STEP_EN.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              start,
  input  logic              abort,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  output logic [WORD_W-1:0] instruct,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output seq_state_e        dbg_state
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] word;
  logic              adv;

`ifdef SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // The store is writable only while no program is executing.
  seq_prog_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (prog_we && (state_q != S_RUN)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        // abort beats HALT and end-of-program; start is ignored here
        if (abort) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else if (adv) begin
          if (is_halt(word) || (pc_q == ADDR_W'(PROG_DEPTH - 1))) begin
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    instruct = NOP_WORD;
    if ((state_q == S_RUN) && adv && !is_halt(word)) instruct = word;
  end

  assign pc        = pc_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
